// File: rtl/id_ex_stage_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: default widths,
// ResultSrc / ALUControl encodings and the packed control bundle.
// Optional build macro used by the top: IDEX_BUBBLE_CNT_EN.
package id_ex_stage_reg_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    // valid rides with the control bits so that one clear wipes both
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [2:0] alu_control;
        logic       alu_src;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// Decode-to-execute bundle. master = decode/hazard side, slave = the
// ID/EX register itself.
interface id_ex_stage_reg_if
    import id_ex_stage_reg_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
);
    logic              stall_e;
    logic              flush_e;

    logic              valid_d;
    logic              RegWrite_d;
    logic [1:0]        ResultSrc_d;
    logic              MemWrite_d;
    logic              jump_d;
    logic              branch_d;
    logic [2:0]        ALUControl_d;
    logic              ALUSrc_d;
    logic [XLEN-1:0]   rd1_d, rd2_d, pc_d, pcplus4_d, immext_d;
    logic [REG_AW-1:0] rs1_d, rs2_d, rd_d;

    logic              valid_e;
    logic              RegWrite_e;
    logic [1:0]        ResultSrc_e;
    logic              MemWrite_e;
    logic              jump_e;
    logic              branch_e;
    logic [2:0]        ALUControl_e;
    logic              ALUSrc_e;
    logic [XLEN-1:0]   rd1_e, rd2_e, pc_e, pcplus4_e, immext_e;
    logic [REG_AW-1:0] rs1_e, rs2_e, rd_e;

    modport master (
        output stall_e, flush_e,
        output valid_d, RegWrite_d, ResultSrc_d, MemWrite_d, jump_d, branch_d,
               ALUControl_d, ALUSrc_d, rd1_d, rd2_d, pc_d, pcplus4_d, immext_d,
               rs1_d, rs2_d, rd_d,
        input  valid_e, RegWrite_e, ResultSrc_e, MemWrite_e, jump_e, branch_e,
               ALUControl_e, ALUSrc_e, rd1_e, rd2_e, pc_e, pcplus4_e, immext_e,
               rs1_e, rs2_e, rd_e
    );

    modport slave (
        input  stall_e, flush_e,
        input  valid_d, RegWrite_d, ResultSrc_d, MemWrite_d, jump_d, branch_d,
               ALUControl_d, ALUSrc_d, rd1_d, rd2_d, pc_d, pcplus4_d, immext_d,
               rs1_d, rs2_d, rd_d,
        output valid_e, RegWrite_e, ResultSrc_e, MemWrite_e, jump_e, branch_e,
               ALUControl_e, ALUSrc_e, rd1_e, rd2_e, pc_e, pcplus4_e, immext_e,
               rs1_e, rs2_e, rd_e
    );

endinterface

// File: rtl/id_ex_stage_reg_pipe_flop_en_clr.sv
// Generic pipeline flop bank: async active-low reset, synchronous clear
// (wins over enable) and load enable.
module pipe_flop_en_clr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    // clear beats enable; otherwise load when enabled, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (clr_i) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register of the 5-stage RV32I core. Flush inserts a
// bubble, stall holds, otherwise the decode bundle is captured. Control
// bits are zeroed whenever an invalid slot is loaded so a bubble can never
// write registers/memory or redirect the PC.
// Optional build macro IDEX_BUBBLE_CNT_EN adds a saturating bubble counter.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    id_ex_stage_reg_if.slave  bus
`ifdef IDEX_BUBBLE_CNT_EN
    ,
    output logic [31:0]       bubble_cnt
`endif
);

    localparam int CW = $bits(ctrl_t);
    localparam int DW = 5 * XLEN + 3 * REG_AW;

    logic          capture;
    logic          bubble_load;
    ctrl_t         ctrl_d;
    ctrl_t         ctrl_q;
    logic [DW-1:0] data_d;
    logic [DW-1:0] data_q;

    assign capture     = ~bus.stall_e;
    // a bubble is loaded on flush, or when capturing an empty decode slot
    assign bubble_load = bus.flush_e | (capture & ~bus.valid_d);

    // pack decode controls; encodings pass through untouched
    always_comb begin
        ctrl_d             = '0;
        ctrl_d.valid       = bus.valid_d;
        ctrl_d.reg_write   = bus.RegWrite_d;
        ctrl_d.result_src  = bus.ResultSrc_d;
        ctrl_d.mem_write   = bus.MemWrite_d;
        ctrl_d.jump        = bus.jump_d;
        ctrl_d.branch      = bus.branch_d;
        ctrl_d.alu_control = bus.ALUControl_d;
        ctrl_d.alu_src     = bus.ALUSrc_d;
    end

    assign data_d = {bus.rd1_d, bus.rd2_d, bus.pc_d, bus.pcplus4_d, bus.immext_d,
                     bus.rs1_d, bus.rs2_d, bus.rd_d};

    pipe_flop_en_clr #(.WIDTH(CW)) u_ctrl_flop (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (capture),
        .clr_i (bubble_load),
        .d_i   (ctrl_d),
        .q_o   (ctrl_q)
    );

    // data of an invalid slot is kept as-is; only a flush wipes it
    pipe_flop_en_clr #(.WIDTH(DW)) u_data_flop (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (capture),
        .clr_i (bus.flush_e),
        .d_i   (data_d),
        .q_o   (data_q)
    );

    assign bus.valid_e      = ctrl_q.valid;
    assign bus.RegWrite_e   = ctrl_q.reg_write;
    assign bus.ResultSrc_e  = ctrl_q.result_src;
    assign bus.MemWrite_e   = ctrl_q.mem_write;
    assign bus.jump_e       = ctrl_q.jump;
    assign bus.branch_e     = ctrl_q.branch;
    assign bus.ALUControl_e = ctrl_q.alu_control;
    assign bus.ALUSrc_e     = ctrl_q.alu_src;

    assign {bus.rd1_e, bus.rd2_e, bus.pc_e, bus.pcplus4_e, bus.immext_e,
            bus.rs1_e, bus.rs2_e, bus.rd_e} = data_q;

`ifdef IDEX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_q;
    logic [31:0] bubble_cnt_d;

    // count bubble loads, sticking at all-ones
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble_load && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    // bubble counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed table-driven bench for id_ex_stage_reg, plus hand sequences for
// async reset and (with IDEX_BUBBLE_CNT_EN) the bubble counter.
module tb_id_ex_stage_reg;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    id_ex_stage_reg_if #(.XLEN(32), .REG_AW(5)) bus ();

`ifdef IDEX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    id_ex_stage_reg #(.XLEN(32), .REG_AW(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave)
`ifdef IDEX_BUBBLE_CNT_EN
        ,
        .bubble_cnt (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl layout: [10]valid [9]RegWrite [8:7]ResultSrc [6]MemWrite
    //              [5]jump [4]branch [3:1]ALUControl [0]ALUSrc
    typedef struct packed {
        logic        st;
        logic        fl;
        logic [10:0] ctrl;
        logic [31:0] rd1;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
    } in_t;

    typedef struct packed {
        logic [10:0] ctrl;
        logic [31:0] rd1;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    localparam int NV = 13;
    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input in_t x);
        bus.stall_e      = x.st;
        bus.flush_e      = x.fl;
        bus.valid_d      = x.ctrl[10];
        bus.RegWrite_d   = x.ctrl[9];
        bus.ResultSrc_d  = x.ctrl[8:7];
        bus.MemWrite_d   = x.ctrl[6];
        bus.jump_d       = x.ctrl[5];
        bus.branch_d     = x.ctrl[4];
        bus.ALUControl_d = x.ctrl[3:1];
        bus.ALUSrc_d     = x.ctrl[0];
        bus.rd1_d        = x.rd1;
        bus.rd2_d        = ~x.rd1;
        bus.pc_d         = x.pc;
        bus.pcplus4_d    = x.pc + 32'd4;
        bus.immext_d     = x.imm;
        bus.rs1_d        = x.rd + 5'd1;
        bus.rs2_d        = x.rd + 5'd2;
        bus.rd_d         = x.rd;
    endtask

    task automatic check_out(input string tag, input out_t e);
        logic cleared;
        cleared = (e.rd1 == 32'd0) && (e.pc == 32'd0);
        chk({tag, " valid_e"},      {31'd0, bus.valid_e},      {31'd0, e.ctrl[10]});
        chk({tag, " RegWrite_e"},   {31'd0, bus.RegWrite_e},   {31'd0, e.ctrl[9]});
        chk({tag, " ResultSrc_e"},  {30'd0, bus.ResultSrc_e},  {30'd0, e.ctrl[8:7]});
        chk({tag, " MemWrite_e"},   {31'd0, bus.MemWrite_e},   {31'd0, e.ctrl[6]});
        chk({tag, " jump_e"},       {31'd0, bus.jump_e},       {31'd0, e.ctrl[5]});
        chk({tag, " branch_e"},     {31'd0, bus.branch_e},     {31'd0, e.ctrl[4]});
        chk({tag, " ALUControl_e"}, {29'd0, bus.ALUControl_e}, {29'd0, e.ctrl[3:1]});
        chk({tag, " ALUSrc_e"},     {31'd0, bus.ALUSrc_e},     {31'd0, e.ctrl[0]});
        chk({tag, " rd1_e"},        bus.rd1_e,                 e.rd1);
        chk({tag, " rd2_e"},        bus.rd2_e,                 cleared ? 32'd0 : ~e.rd1);
        chk({tag, " pc_e"},         bus.pc_e,                  e.pc);
        chk({tag, " pcplus4_e"},    bus.pcplus4_e,             cleared ? 32'd0 : e.pc + 32'd4);
        chk({tag, " immext_e"},     bus.immext_e,              e.imm);
        chk({tag, " rd_e"},         {27'd0, bus.rd_e},         {27'd0, e.rd});
        chk({tag, " rs1_e"},        {27'd0, bus.rs1_e},        cleared ? 32'd0 : {27'd0, e.rd + 5'd1});
        chk({tag, " rs2_e"},        {27'd0, bus.rs2_e},        cleared ? 32'd0 : {27'd0, e.rd + 5'd2});
        if (!bus.valid_e) begin
            chk({tag, " bubble_ctrl"},
                {28'd0, bus.RegWrite_e, bus.MemWrite_e, bus.jump_e, bus.branch_e}, 32'd0);
        end
    endtask

    initial begin
        out_t zero_o;
        checks = 0;
        errors = 0;
        zero_o = '0;

        //            st    fl    ctrl                 rd1           pc            imm           rd
        tbl[0]  = '{'{1'b0, 1'b0, 11'b1_1_00_0_0_0_001_0, 32'h5,  32'h0,   32'h0,        5'd7},
                    '{      11'b1_1_00_0_0_0_001_0, 32'h5,  32'h0,   32'h0,        5'd7}};
        tbl[1]  = '{'{1'b0, 1'b0, 11'b1_1_01_0_0_0_000_1, 32'h11, 32'h100, 32'h20,       5'd3},
                    '{      11'b1_1_01_0_0_0_000_1, 32'h11, 32'h100, 32'h20,       5'd3}};
        tbl[2]  = '{'{1'b1, 1'b0, 11'b1_0_10_0_0_0_010_0, 32'h22, 32'h104, 32'h24,       5'd4},
                    '{      11'b1_1_01_0_0_0_000_1, 32'h11, 32'h100, 32'h20,       5'd3}};
        tbl[3]  = tbl[2];
        tbl[4]  = tbl[2];
        tbl[5]  = '{'{1'b0, 1'b0, 11'b1_0_10_0_0_0_010_0, 32'h22, 32'h104, 32'h24,       5'd4},
                    '{      11'b1_0_10_0_0_0_010_0, 32'h22, 32'h104, 32'h24,       5'd4}};
        tbl[6]  = '{'{1'b0, 1'b0, 11'b1_0_00_1_0_1_001_0, 32'h33, 32'h108, 32'h8,        5'd0},
                    '{      11'b1_0_00_1_0_1_001_0, 32'h33, 32'h108, 32'h8,        5'd0}};
        tbl[7]  = '{'{1'b0, 1'b1, 11'b1_1_00_0_1_0_000_0, 32'h34, 32'h10C, 32'h4,        5'd2},
                    zero_o};
        tbl[8]  = '{'{1'b0, 1'b0, 11'b1_1_10_0_1_0_000_0, 32'h44, 32'h200, 32'h10,       5'd1},
                    '{      11'b1_1_10_0_1_0_000_0, 32'h44, 32'h200, 32'h10,       5'd1}};
        tbl[9]  = '{'{1'b1, 1'b1, 11'b1_0_00_0_1_0_000_0, 32'h45, 32'h204, 32'h14,       5'd5},
                    zero_o};
        tbl[10] = '{'{1'b0, 1'b0, 11'b0_1_01_0_1_0_101_1, 32'h55, 32'h300, 32'hFFFF_FFF0, 5'd9},
                    '{      11'b0_0_00_0_0_0_000_0, 32'h55, 32'h300, 32'hFFFF_FFF0, 5'd9}};
        tbl[11] = '{'{1'b1, 1'b0, 11'b0_1_00_0_1_1_000_0, 32'h66, 32'h304, 32'h1,        5'd10},
                    '{      11'b0_0_00_0_0_0_000_0, 32'h55, 32'h300, 32'hFFFF_FFF0, 5'd9}};
        tbl[12] = '{'{1'b0, 1'b0, 11'b1_1_11_0_0_0_111_1, 32'h77, 32'h400, 32'h8000_0000, 5'd31},
                    '{      11'b1_1_11_0_0_0_111_1, 32'h77, 32'h400, 32'h8000_0000, 5'd31}};

        // power-on reset with live decode inputs
        rst_n = 1'b0;
        drive(tbl[0].i);
        #12;
        check_out("por", zero_o);
`ifdef IDEX_BUBBLE_CNT_EN
        chk("por bubble_cnt", bubble_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            drive(tbl[k].i);
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", k), tbl[k].o);
        end

`ifdef IDEX_BUBBLE_CNT_EN
        chk("bubble_cnt after table", bubble_cnt, 32'd3);
`endif

        // async reset mid-cycle while stalling, RegWrite_d high
        #2;
        drive('{1'b1, 1'b0, 11'b1_1_00_1_1_1_011_1, 32'h99, 32'h500, 32'h3, 5'd6});
        rst_n = 1'b0;
        #1;
        check_out("async_rst", zero_o);
`ifdef IDEX_BUBBLE_CNT_EN
        chk("async_rst bubble_cnt", bubble_cnt, 32'd0);
`endif

        // release, then a clean capture on the next edge
        @(negedge clk);
        rst_n = 1'b1;
        drive(tbl[0].i);
        #1;
        check_out("post_release_pre_edge", zero_o);
        @(posedge clk);
        #1;
        check_out("post_release_capture", tbl[0].o);

`ifdef IDEX_BUBBLE_CNT_EN
        // saturation: preload to all-ones, then one flush
        @(negedge clk);
        force dut.bubble_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.bubble_cnt_q;
        bus.flush_e = 1'b1;
        @(posedge clk);
        #1;
        chk("bubble_cnt saturate", bubble_cnt, 32'hFFFF_FFFF);
        check_out("sat_flush", zero_o);
        @(negedge clk);
        bus.flush_e = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Pipeline register between Decode (main/ALU decoder, register file, immediate extend) and Execute in the 5-stage RV32I pipeline.
- Captures the decode-stage control bundle (RegWrite, ResultSrc, MemWrite, jump, branch, ALUControl, ALUSrc) plus operands, PCs, register indices and immediate.
- Presents them to the Execute stage, which forms PCSrc = jump | (branch & zero).
- Supports stall (hold) and flush (bubble insert) from the hazard unit, and tracks a valid bit per slot.

Parameters:
- XLEN, 32, datapath width for operands, PC and immediate.
- REG_AW, 5, register index width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- stall_e  input  1  hold current contents
- flush_e  input  1  replace contents with a bubble on next edge
- valid_d  input  1  decode slot holds a real instruction
- RegWrite_d  input  1  decode control
- ResultSrc_d  input  2  decode control
- MemWrite_d  input  1  decode control
- jump_d  input  1  decode control
- branch_d  input  1  decode control
- ALUControl_d  input  3  decode control
- ALUSrc_d  input  1  decode control
- rd1_d, rd2_d  input  XLEN  register file read data
- pc_d, pcplus4_d  input  XLEN  decode PC and PC+4
- immext_d  input  XLEN  extended immediate
- rs1_d, rs2_d, rd_d  input  REG_AW  register indices
- valid_e  output  1  execute slot valid
- RegWrite_e, ResultSrc_e, MemWrite_e, jump_e, branch_e, ALUControl_e, ALUSrc_e  output  as _d  registered control
- rd1_e, rd2_e, pc_e, pcplus4_e, immext_e  output  XLEN  registered data
- rs1_e, rs2_e, rd_e  output  REG_AW  registered indices

Behaviour:
- Reset (rst_n=0, asynchronous, any time): every output is 0. valid_e=0, so the stage holds a bubble. Release takes effect at the next rising clk edge.
- Latency: exactly 1 cycle from _d to _e. There is no combinational path from input to output.
- Priority at each rising edge: flush_e > stall_e > capture.
  - flush_e=1: all outputs cleared to 0, including valid_e, RegWrite_e, MemWrite_e, jump_e and branch_e. This applies regardless of stall_e.
  - stall_e=1 with flush_e=0: all outputs hold their values.
  - Otherwise: all _e outputs take their _d values.
- Bubble guarantee: when valid_e=0, the clear/reset paths also give RegWrite_e=MemWrite_e=jump_e=branch_e=0.
- Invalid capture: if valid_d=0 is captured, the control bits are forced to 0 on capture. Data fields are captured as-is.
- No control bit may ever be 1 while valid_e=0.
- ResultSrc encoding passes through unchanged: 00 ALU, 01 memory, 10 PC+4. 11 is reserved and passed through.
- The register never decodes or modifies ALUControl.
- Reset asserted mid-stall or mid-flush: reset wins immediately.

Optional Feature:
- Macro IDEX_BUBBLE_CNT_EN.
- Defined:
  - Adds output port bubble_cnt, width 32.
  - Reset to 0.
  - Increments on each rising edge where the stage loads a bubble: flush_e=1, or a capture with valid_d=0.
  - Saturates at 0xFFFF_FFFF.
  - Stall cycles are not counted.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - ResultSrc encodings: RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10.
  - ALUControl encodings: ADD=000, SUB=001, AND=010, OR=011, SLT=101.
  - XLEN and REG_AW defaults.
- One natural sub-module, pipe_flop_en_clr: parameterised width, with async active-low reset, synchronous clear, and enable.
  - Instantiated once for the control bundle and once for the data bundle.
  - The control instance clears on flush_e or on a capture with valid_d=0.

Test Plan:
- Reset then capture: assert rst_n=0 mid-cycle with RegWrite_d=1 → all outputs 0 immediately. Release, drive valid_d=1, RegWrite_d=1, ALUControl_d=001, rd1_d=0x0000_0005, rd_d=7 → next edge valid_e=1, RegWrite_e=1, ALUControl_e=001, rd1_e=5, rd_e=7.
- Stall hold: load pc_d=0x100. Then stall_e=1 for 3 cycles while pc_d=0x104 → pc_e stays 0x100. Deassert stall → pc_e=0x104 next edge.
- Flush: load MemWrite_d=1, branch_d=1, then flush_e=1 → next edge valid_e=0, MemWrite_e=0, branch_e=0, rd1_e=0.
- Flush and stall together: stall_e=1, flush_e=1 with jump_d=1 → outputs cleared, jump_e=0 (flush wins).
- Invalid capture: valid_d=0, RegWrite_d=1, jump_d=1, immext_d=0xFFFF_FFF0 → valid_e=0, RegWrite_e=0, jump_e=0, immext_e=0xFFFF_FFF0.
- With IDEX_BUBBLE_CNT_EN: 2 flush cycles, 1 stall cycle, 1 valid_d=0 capture → bubble_cnt=3. Preload the counter via force to 0xFFFF_FFFF plus one flush → remains 0xFFFF_FFFF.
